serial_paralelo: RTL and testbench

// - Receive side of the link: consumes the serial bit stream produced by the parallel-to-serial stage and rebuilds bytes.
// - Hunts for comma 8'hBC, locks byte alignment, declares the link active after BC_LOCK consecutive aligned commas.
// - Once active, it forwards non-comma bytes with a one-cycle valid strobe.
// - Runs entirely on clk_32f (one bit per cycle).

---
 rtl/serial_paralelo_pkg.sv | 14 +
 rtl/sp_shift_counter.sv | 38 +++
 rtl/serial_paralelo.sv | 146 ++++++++++++++
 tb/tb_serial_paralelo.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/serial_paralelo_pkg.sv
// Shared link constants for the serial/parallel stages: comma symbol, FSM state encoding, default lock depth.
package serial_paralelo_defs;

  localparam int         SP_WIDTH   = 8;
  localparam logic [7:0] SP_COMMA   = 8'hBC;
  localparam int         SP_BC_LOCK = 4;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ALIGNED = 2'd1,
    ACTIVE  = 2'd2
  } sp_state_e;

endpackage

// File: rtl/sp_shift_counter.sv
// MSB-first deserializer front end: shift register exposing the current window plus a mod-WIDTH
// bit counter whose last count marks the byte boundary.
module sp_shift_counter
  import serial_paralelo_defs::*;
#(
  parameter int WIDTH = SP_WIDTH
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             clr,
  input  logic             data_in,
  output logic [WIDTH-1:0] window,
  output logic             boundary
);

  localparam int            CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  // Only WIDTH-1 history bits are needed; the current bit completes the window.
  logic [WIDTH-2:0] sr;
  logic [CW-1:0]    bit_cnt;

  assign window   = {sr, data_in};
  assign boundary = (bit_cnt == CNT_LST);

  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else begin
      sr <= window[WIDTH-2:0];
      if (clr || boundary) bit_cnt <= '0;
      else                 bit_cnt <= bit_cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/serial_paralelo.sv
// Serial-to-parallel receiver: comma hunt, byte alignment lock and data byte strobing.
// Optional macro SP_RESYNC_EN adds misalignment detection that drops a stale lock back to SEARCH.
//
// state   | meaning
// SEARCH  | sliding comparison of every window against COMMA
// ALIGNED | boundary fixed, counting consecutive boundary commas toward BC_LOCK
// ACTIVE  | locked; non-comma boundary bytes are forwarded with valid_out
module serial_paralelo
  import serial_paralelo_defs::*;
#(
  parameter int               WIDTH   = SP_WIDTH,
  parameter logic [WIDTH-1:0] COMMA   = WIDTH'(SP_COMMA),
  parameter int               BC_LOCK = SP_BC_LOCK
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             active
);

  localparam int             BCW    = $clog2(BC_LOCK + 1);
  localparam logic [BCW-1:0] BC_MAX = BCW'(BC_LOCK);
  localparam logic [BCW-1:0] BC_LST = BCW'(BC_LOCK - 1);
  localparam logic [BCW-1:0] BC_ONE = BCW'(1);

  sp_state_e        state, state_nxt;
  logic [BCW-1:0]   bc_cnt, bc_nxt;
  logic             active_nxt, valid_nxt;
  logic [WIDTH-1:0] data_nxt;
  logic [WIDTH-1:0] window;
  logic             boundary;
  logic             is_comma;

  sp_shift_counter #(.WIDTH(WIDTH)) u_shift (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .clr      (state == SEARCH),
    .data_in  (data_in),
    .window   (window),
    .boundary (boundary)
  );

  assign is_comma = (window == COMMA);

`ifdef SP_RESYNC_EN
  // mis_seen: off-boundary comma seen in the current byte period; bad_prev: previous period was misaligned.
  logic mis_seen, mis_nxt;
  logic bad_prev, bad_nxt;
`endif

  always_comb begin
    state_nxt  = state;
    bc_nxt     = bc_cnt;
    active_nxt = active;
    data_nxt   = data_out;
    valid_nxt  = 1'b0;
`ifdef SP_RESYNC_EN
    mis_nxt    = 1'b0;
    bad_nxt    = 1'b0;
`endif
    case (state)
      SEARCH: begin
        if (is_comma) begin
          bc_nxt = BC_ONE;
          if (BC_LOCK == 1) begin
            state_nxt  = ACTIVE;
            active_nxt = 1'b1;
          end else begin
            state_nxt = ALIGNED;
          end
        end
      end
      ALIGNED: begin
        if (boundary) begin
          if (!is_comma) begin
            state_nxt = SEARCH;
            bc_nxt    = '0;
          end else if (bc_cnt >= BC_LST) begin
            bc_nxt     = BC_MAX;
            state_nxt  = ACTIVE;
            active_nxt = 1'b1;
          end else begin
            bc_nxt = bc_cnt + BC_ONE;
          end
        end
      end
      ACTIVE: begin
        if (boundary && !is_comma) begin
          data_nxt  = window;
          valid_nxt = 1'b1;
        end
`ifdef SP_RESYNC_EN
        if (!boundary) begin
          mis_nxt = mis_seen | is_comma;
          bad_nxt = bad_prev;
        end else if (mis_seen && !is_comma) begin
          if (bad_prev) begin
            state_nxt  = SEARCH;
            bc_nxt     = '0;
            active_nxt = 1'b0;
            valid_nxt  = 1'b0;
            data_nxt   = data_out;
          end else begin
            bad_nxt = 1'b1;
          end
        end
`endif
      end
      default: begin
        state_nxt = SEARCH;
        bc_nxt    = '0;
      end
    endcase
  end

  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      state     <= SEARCH;
      bc_cnt    <= '0;
      active    <= 1'b0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      state     <= state_nxt;
      bc_cnt    <= bc_nxt;
      active    <= active_nxt;
      data_out  <= data_nxt;
      valid_out <= valid_nxt;
    end
  end

`ifdef SP_RESYNC_EN
  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      mis_seen <= 1'b0;
      bad_prev <= 1'b0;
    end else begin
      mis_seen <= mis_nxt;
      bad_prev <= bad_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_serial_paralelo.sv
// Directed bench for serial_paralelo: reset, lock, data strobes, lock loss, mid-byte reset and slip.
module tb_serial_paralelo;

  logic       clk_32f = 1'b0;
  logic       reset   = 1'b0;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] din;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_active;
  } vec_t;

  vec_t tbl_a[10];
  vec_t tbl_b[8];

  serial_paralelo dut (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .active    (active)
  );

  always #5 clk_32f = ~clk_32f;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one bit on the falling edge; return just after the rising edge that samples it.
  task automatic send_bit(input logic b);
    @(negedge clk_32f);
    data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  task automatic send_vec(input string name, input vec_t v);
    logic [7:0] d;
    d = v.din;
    for (int i = 7; i >= 0; i--) begin
      send_bit(d[i]);
      if (i != 0) check({name, " mid-byte valid"}, valid_out, 1'b0);
    end
    check({name, " valid"},  valid_out, v.exp_valid);
    check({name, " data"},   data_out,  v.exp_data);
    check({name, " active"}, active,    v.exp_active);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] bc;
    int         n;
    int         dropped_at;
    logic       ever_low;
    logic       valid_at_drop;
    vec_t       v;

    bc = 8'hBC;

    // lock from junk, data strobes, then idle comma between data while active
    tbl_a[0] = '{8'hBC, 1'b0, 8'h00, 1'b0};
    tbl_a[1] = '{8'hBC, 1'b0, 8'h00, 1'b0};
    tbl_a[2] = '{8'hBC, 1'b0, 8'h00, 1'b0};
    tbl_a[3] = '{8'hBC, 1'b0, 8'h00, 1'b1};
    tbl_a[4] = '{8'hFF, 1'b1, 8'hFF, 1'b1};
    tbl_a[5] = '{8'hEE, 1'b1, 8'hEE, 1'b1};
    tbl_a[6] = '{8'hDD, 1'b1, 8'hDD, 1'b1};
    tbl_a[7] = '{8'hAA, 1'b1, 8'hAA, 1'b1};
    tbl_a[8] = '{8'hBC, 1'b0, 8'hAA, 1'b1};
    tbl_a[9] = '{8'hCC, 1'b1, 8'hCC, 1'b1};

    // after mid-byte reset: partial lock lost on AA, fresh 4-comma relock, then data
    tbl_b[0] = '{8'hBC, 1'b0, 8'h00, 1'b0};
    tbl_b[1] = '{8'hBC, 1'b0, 8'h00, 1'b0};
    tbl_b[2] = '{8'hAA, 1'b0, 8'h00, 1'b0};
    tbl_b[3] = '{8'hBC, 1'b0, 8'h00, 1'b0};
    tbl_b[4] = '{8'hBC, 1'b0, 8'h00, 1'b0};
    tbl_b[5] = '{8'hBC, 1'b0, 8'h00, 1'b0};
    tbl_b[6] = '{8'hBC, 1'b0, 8'h00, 1'b1};
    tbl_b[7] = '{8'h55, 1'b1, 8'h55, 1'b1};

    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send_bit(i[0]);
      check("reset data_out",  data_out,  8'h00);
      check("reset valid_out", valid_out, 1'b0);
      check("reset active",    active,    1'b0);
    end

    reset = 1'b1;
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);

    for (int k = 0; k < 10; k++) begin
      v = tbl_a[k];
      send_vec($sformatf("lock_a[%0d]", k), v);
    end

    // reset pulse three bits into a byte while locked
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    @(negedge clk_32f);
    reset   = 1'b0;
    data_in = 1'b1;
    @(posedge clk_32f);
    #1;
    check("midreset data_out",  data_out,  8'h00);
    check("midreset valid_out", valid_out, 1'b0);
    check("midreset active",    active,    1'b0);
    @(negedge clk_32f);
    reset = 1'b1;

    for (int k = 0; k < 8; k++) begin
      v = tbl_b[k];
      send_vec($sformatf("relock_b[%0d]", k), v);
    end

    v = '{8'hBC, 1'b0, 8'h55, 1'b1};
    send_vec("pre-slip idle0", v);
    send_vec("pre-slip idle1", v);

    // slip the comma stream by three bits
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    n             = 0;
    dropped_at    = -1;
    ever_low      = 1'b0;
    valid_at_drop = 1'b0;
    for (int b = 0; b < 8; b++) begin
      for (int i = 7; i >= 0; i--) begin
        send_bit(bc[i]);
        n++;
        if (!active) begin
          ever_low = 1'b1;
          if (dropped_at < 0) begin
            dropped_at    = n;
            valid_at_drop = valid_out;
          end
        end
      end
    end

`ifdef SP_RESYNC_EN
    check("slip active dropped in time", (dropped_at > 0 && dropped_at <= 24), 1'b1);
    check("slip valid at drop", valid_at_drop, 1'b0);
    check("slip relocked active", active, 1'b1);
    v = '{8'hF0, 1'b1, 8'hF0, 1'b1};
    send_vec("post-relock data", v);
`else
    check("slip active never dropped", ever_low, 1'b0);
    check("slip final active", active, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
